// File: rtl/mult_ctrl_if.sv
// Handshake and datapath-strobe bundle between mult_ctrl and the multiplier datapath.
// MULT_CTRL_PERF_CNT_EN adds the cyc_cnt cycle counter output.
interface mult_ctrl_if;
    logic        start;
    logic        zero;
    logic        ld_a;
    logic        ld_b;
    logic        ld_p;
    logic        cr_p;
    logic        dc_b;
    logic        busy;
    logic        done;
    logic        err;
`ifdef MULT_CTRL_PERF_CNT_EN
    logic [15:0] cyc_cnt;
`endif

    modport master (
        input  start,
        input  zero,
        output ld_a,
        output ld_b,
        output ld_p,
        output cr_p,
        output dc_b,
        output busy,
        output done,
        output err
`ifdef MULT_CTRL_PERF_CNT_EN
        , output cyc_cnt
`endif
    );

    modport slave (
        output start,
        output zero,
        input  ld_a,
        input  ld_b,
        input  ld_p,
        input  cr_p,
        input  dc_b,
        input  busy,
        input  done,
        input  err
`ifdef MULT_CTRL_PERF_CNT_EN
        , input cyc_cnt
`endif
    );
endinterface

// File: rtl/mult_ctrl.sv
// Control FSM for the repeated-addition multiplier: sequences A/B load, P clear, add/decrement loop.
// Optional MULT_CTRL_PERF_CNT_EN adds a saturating busy-cycle counter (cyc_cnt).
module mult_ctrl #(
    parameter int                ZERO_LAT = 1,
    parameter int                ITER_W   = 16,
    parameter logic [ITER_W-1:0] MAX_ITER = {ITER_W{1'b1}}
) (
    input logic         clk,
    input logic         rst_n,
    mult_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CHECK  = 3'd3,
        S_ADD    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0]        ZL       = 2'(ZERO_LAT);
    localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0] ITER_SAT = {ITER_W{1'b1}};

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [1:0]        wait_q, wait_d;
    logic              err_q, err_d;
    logic              ld_a_q, ld_a_d;
    logic              ld_b_q, ld_b_d;
    logic              ld_p_q, ld_p_d;
    logic              cr_p_q, cr_p_d;
    logic              dc_b_q, dc_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef MULT_CTRL_PERF_CNT_EN
    logic [15:0]       cyc_q, cyc_d;
`endif

    // Next-state, counters and error flag
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD_A;
                    iter_d  = {ITER_W{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                wait_d  = 2'd0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // wait_q only ever climbs to ZL, so != is the "still waiting" test
                if (wait_q != ZL) begin
                    wait_d = wait_q + 2'd1;
                end else if (bus.zero) begin
                    state_d = S_DONE;
                end else if (iter_q == MAX_ITER) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (iter_q == ITER_SAT) begin
                    iter_d = iter_q;
                end else begin
                    iter_d = iter_q + ITER_ONE;
                end
                wait_d  = 2'd0;
                state_d = S_CHECK;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the flopped strobes line up with the state register
    always_comb begin
        ld_a_d = 1'b0;
        ld_b_d = 1'b0;
        ld_p_d = 1'b0;
        cr_p_d = 1'b0;
        dc_b_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_LOAD_A: ld_a_d = 1'b1;
            S_LOAD_B: begin
                ld_b_d = 1'b1;
                cr_p_d = 1'b1;
            end
            S_ADD: begin
                ld_p_d = 1'b1;
                dc_b_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ld_a_d = 1'b0;
        endcase
    end

`ifdef MULT_CTRL_PERF_CNT_EN
    // Busy-cycle counter: value in each busy cycle counts that cycle, holds through IDLE
    always_comb begin
        cyc_d = cyc_q;
        if (state_d == S_IDLE) begin
            cyc_d = cyc_q;
        end else if (state_q == S_IDLE) begin
            cyc_d = 16'd1;
        end else if (cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end else begin
            cyc_d = cyc_q;
        end
    end
`endif

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= {ITER_W{1'b0}};
            wait_q  <= 2'd0;
            err_q   <= 1'b0;
            ld_a_q  <= 1'b0;
            ld_b_q  <= 1'b0;
            ld_p_q  <= 1'b0;
            cr_p_q  <= 1'b0;
            dc_b_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_CTRL_PERF_CNT_EN
            cyc_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            ld_a_q  <= ld_a_d;
            ld_b_q  <= ld_b_d;
            ld_p_q  <= ld_p_d;
            cr_p_q  <= cr_p_d;
            dc_b_q  <= dc_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULT_CTRL_PERF_CNT_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    assign bus.ld_a = ld_a_q;
    assign bus.ld_b = ld_b_q;
    assign bus.ld_p = ld_p_q;
    assign bus.cr_p = cr_p_q;
    assign bus.dc_b = dc_b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
`ifdef MULT_CTRL_PERF_CNT_EN
    assign bus.cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: four controller+datapath instances (varied ZERO_LAT / MAX_ITER),
// a schedule-based reference model checked every cycle, plus directed literal checks.
module tb_mult_ctrl;
    localparam int NI   = 4;
    localparam int SMAX = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI-1:0] start_v;
    logic [7:0]    dataa_v [NI];
    logic [7:0]    datab_v [NI];
    logic [7:0]    outv    [NI];
    logic [15:0]   p_a     [NI];
    logic [7:0]    b_a     [NI];
`ifdef MULT_CTRL_PERF_CNT_EN
    logic [15:0]   cyc_a   [NI];
    int            cyc_m   [NI];
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  sch   [NI][SMAX];
    int          len_m [NI];
    int          rp_m  [NI];
    logic [7:0]  cur_m [NI];
    logic        err_m [NI];
    logic [15:0] pm    [NI];
    logic [7:0]  bm    [NI];

    function automatic int zl_of(input int g);
        case (g)
            2:       return 0;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int max_of(input int g);
        case (g)
            1:       return 4;
            3:       return 3;
            default: return 65535;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int ZL = zl_of(g);
        localparam int MX = max_of(g);
        mult_ctrl_if ifc ();
        logic [7:0]  a_r  = 8'd0;
        logic [7:0]  b_r  = 8'd0;
        logic [15:0] p_r  = 16'd0;
        logic [2:0]  zp_r = 3'd0;

        assign ifc.start = start_v[g];
        if (ZL == 0) begin : g_z0
            assign ifc.zero = (b_r == 8'd0);
        end else begin : g_zn
            assign ifc.zero = zp_r[ZL-1];
        end

        // Datapath stand-in: A/B/P registers and a delayed B==0 comparator
        always @(posedge clk) begin
            if (ifc.ld_a) a_r <= dataa_v[g];
            if (ifc.ld_b) b_r <= datab_v[g];
            else if (ifc.dc_b) b_r <= b_r - 8'd1;
            if (ifc.cr_p) p_r <= 16'd0;
            else if (ifc.ld_p) p_r <= p_r + {8'd0, a_r};
            zp_r <= {zp_r[1:0], (b_r == 8'd0)};
        end

        assign outv[g] = {ifc.ld_a, ifc.ld_b, ifc.ld_p, ifc.cr_p, ifc.dc_b, ifc.busy, ifc.done, ifc.err};
        assign p_a[g]  = p_r;
        assign b_a[g]  = b_r;
`ifdef MULT_CTRL_PERF_CNT_EN
        assign cyc_a[g] = ifc.cyc_cnt;
`endif

        mult_ctrl #(.ZERO_LAT(ZL), .ITER_W(16), .MAX_ITER(16'(MX))) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
    end

    task automatic chk(input string nm, input int g, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t: got %0h want %0h", nm, g, $time, act, exp);
        end
    endtask

    // Expected per-cycle output vectors {ld_a,ld_b,ld_p,cr_p,dc_b,busy,done,err} for one operation
    task automatic build(input int g);
        int n, mx, zl, nadd, k;
        logic ovf;
        n    = int'(datab_v[g]);
        mx   = max_of(g);
        zl   = zl_of(g);
        ovf  = (n > mx);
        nadd = ovf ? mx : n;
        k = 0;
        sch[g][k] = 8'h84; k++;
        sch[g][k] = 8'h54; k++;
        for (int i = 0; i < nadd; i++) begin
            for (int j = 0; j <= zl; j++) begin sch[g][k] = 8'h04; k++; end
            sch[g][k] = 8'h2C; k++;
        end
        for (int j = 0; j <= zl; j++) begin sch[g][k] = 8'h04; k++; end
        sch[g][k] = {7'b0000011, ovf}; k++;
        len_m[g] = k;
        rp_m[g]  = 0;
        err_m[g] = ovf;
        pm[g]    = 16'(int'(dataa_v[g]) * nadd);
        bm[g]    = 8'(n - nadd);
    endtask

    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
`ifdef MULT_CTRL_PERF_CNT_EN
            chk("cyc_cnt", g, int'(cyc_a[g]), rst_n ? cyc_m[g] : 0);
`endif
            if (!rst_n) begin
                chk("rst_outs", g, int'(outv[g]), 0);
                cur_m[g] = 8'h00;
                len_m[g] = 0;
                rp_m[g]  = 0;
                err_m[g] = 1'b0;
`ifdef MULT_CTRL_PERF_CNT_EN
                cyc_m[g] = 0;
`endif
            end else begin
                chk("outs", g, int'(outv[g]), int'(cur_m[g]));
                if (cur_m[g][1]) begin
                    chk("p_final", g, int'(p_a[g]), int'(pm[g]));
                    chk("b_final", g, int'(b_a[g]), int'(bm[g]));
                end
                if (rp_m[g] < len_m[g]) begin
                    cur_m[g] = sch[g][rp_m[g]];
                    rp_m[g]++;
`ifdef MULT_CTRL_PERF_CNT_EN
                    if (cyc_m[g] < 65535) cyc_m[g]++;
`endif
                end else if (!cur_m[g][2] && start_v[g]) begin
                    build(g);
                    cur_m[g] = sch[g][0];
                    rp_m[g]  = 1;
`ifdef MULT_CTRL_PERF_CNT_EN
                    cyc_m[g] = 1;
`endif
                end else begin
                    cur_m[g] = {7'd0, err_m[g]};
                end
            end
        end
    endtask

    task automatic run_op(input int g, input int a, input int b, input bit pulse,
                          output int dcyc, output int nadd);
        bit pulsed;
        pulsed = 1'b0;
        @(posedge clk); #1;
        dataa_v[g] = 8'(a);
        datab_v[g] = 8'(b);
        start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
        dcyc = 1;
        nadd = 0;
        chk("load_a_cycle", g, int'(outv[g]), 32'h84);
        while (!outv[g][1] && dcyc < 2000) begin
            start_v[g] = 1'b0;
            if (dcyc == 2) chk("load_b_cycle", g, int'(outv[g]), 32'h54);
            if (outv[g][5]) begin
                nadd++;
                if (pulse && !pulsed) begin
                    start_v[g] = 1'b1;
                    pulsed = 1'b1;
                end
            end
            @(posedge clk); #1;
            dcyc++;
        end
        start_v[g] = 1'b0;
        chk("done_seen", g, int'(outv[g][1]), 1);
    endtask

    task automatic finish_chk(input int g, input int exp_p, input int exp_err);
        chk("p_at_done", g, int'(p_a[g]), exp_p);
        chk("err_at_done", g, int'(outv[g][0]), exp_err);
        @(posedge clk); #1;
        chk("idle_after_done", g, int'(outv[g][2:1]), 0);
    endtask

    initial begin
        int dc, na, n;
        bit any_busy;
        rst_n   = 1'b0;
        start_v = '0;
        for (int g = 0; g < NI; g++) begin
            dataa_v[g] = 8'd0;
            datab_v[g] = 8'd0;
        end
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 5 x 3 with ZERO_LAT=1
        run_op(0, 5, 3, 1'b0, dc, na);
        chk("p1_done_cycle", 0, dc, 14);
        chk("p1_adds", 0, na, 3);
`ifdef MULT_CTRL_PERF_CNT_EN
        chk("p1_cyc_cnt", 0, int'(cyc_a[0]), 14);
`endif
        finish_chk(0, 15, 0);

        // B = 0 at load
        run_op(0, 7, 0, 1'b0, dc, na);
        chk("b0_done_cycle", 0, dc, 5);
        chk("b0_adds", 0, na, 0);
        finish_chk(0, 0, 0);

        // iteration limit 4 with B=10
        run_op(1, 6, 10, 1'b0, dc, na);
        chk("lim_done_cycle", 1, dc, 17);
        chk("lim_adds", 1, na, 4);
        chk("lim_b_left", 1, int'(b_a[1]), 6);
        finish_chk(1, 24, 1);
        chk("err_held", 1, int'(outv[1][0]), 1);
        run_op(1, 3, 2, 1'b0, dc, na);
        finish_chk(1, 6, 0);
        // zero and limit reached together: zero wins
        run_op(1, 5, 4, 1'b0, dc, na);
        chk("lim_eq_adds", 1, na, 4);
        finish_chk(1, 20, 0);

        // start pulsed during ADD is ignored
        run_op(0, 2, 5, 1'b1, dc, na);
        chk("pulse_done_cycle", 0, dc, 20);
        finish_chk(0, 10, 0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_second_done", 0, int'(outv[0][2:1]), 0);
        end

        // asynchronous reset mid-CHECK
        @(posedge clk); #1;
        dataa_v[0] = 8'd1;
        datab_v[0] = 8'd200;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        n = 0;
        while ((n < 6 || outv[0] != 8'h04) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_check", 0, int'(outv[0]), 32'h04);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) chk("async_rst_drop", g, int'(outv[g]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(0, 3, 2, 1'b0, dc, na);
        chk("post_rst_done_cycle", 0, dc, 11);
        finish_chk(0, 6, 0);

        // ZERO_LAT=0 and ZERO_LAT=3
        run_op(2, 4, 2, 1'b0, dc, na);
        chk("zl0_done_cycle", 2, dc, 8);
        finish_chk(2, 8, 0);
        run_op(3, 9, 3, 1'b0, dc, na);
        chk("zl3_done_cycle", 3, dc, 22);
        finish_chk(3, 27, 0);

        // randomized traffic on all instances, model-checked every cycle
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                if (!outv[g][2] && $urandom_range(0, 2) == 0) begin
                    dataa_v[g] = 8'($urandom_range(0, 255));
                    datab_v[g] = 8'($urandom_range(0, 12));
                end
                start_v[g] = ($urandom_range(0, 2) == 0);
            end
        end
        start_v = '0;
        n = 0;
        any_busy = 1'b1;
        while (any_busy && n < 500) begin
            @(posedge clk); #1;
            n++;
            any_busy = 1'b0;
            for (int g = 0; g < NI; g++) if (outv[g][2]) any_busy = 1'b1;
        end
        chk("drain_idle", 0, int'(any_busy), 0);
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
